song_sequencer: RTL

- Upstream note source for the piano front end: plays a fixed tune (Ode to Joy, first phrase) from an internal ROM.
- Emits a 4-bit note code per beat, in the same encoding the switch decoder uses. The downstream mux uses that code to select the matching frequency clock.
- Tempo is set by a tick counter derived from CLK.
- Supports start, stop and pause control plus status flags.

---
 rtl/song_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/song_sequencer.sv
// -----------------------------------------------------------------------------
// song_sequencer
//   Plays a fixed tune (first phrase of Ode to Joy) from an internal ROM as a
//   stream of 4-bit note codes. The codes use the switch decoder's encoding,
//   so the downstream mux can pick the matching frequency clock.
//   Each ROM entry is {note[3:0], beats[1:0]}. An entry lasts
//   beats*TICKS_PER_BEAT cycles: a sounding part, then GAP_TICKS silent
//   cycles for articulation.
//
//   Optional build macro: SONG_SEQUENCER_LOOP_EN
//     When defined, the tune repeats. After the last entry, done still
//     pulses, but playback wraps straight back to entry 0. It runs until
//     stop or RESET.
//
// Ports
//   CLK        in   system clock
//   RESET      in   asynchronous, active-high reset
//   start      in   1-cycle pulse, begins playback from entry 0 when idle
//   stop       in   1-cycle pulse, aborts playback (wins over start/pause)
//   pause      in   level, freezes playback while high (no effect when idle)
//   note       out  [3:0] note code 0=C4 .. 7=C5, 8=none
//   note_valid out  note is 0..7 and sounding
//   busy       out  sequencer is in SOUND or GAP
//   index      out  [3:0] ROM entry currently playing
//   done       out  1-cycle pulse when the last entry finishes
// -----------------------------------------------------------------------------
module song_sequencer #(
  parameter int TICKS_PER_BEAT = 25_000_000,
  parameter int GAP_TICKS      = 2_500_000,
  parameter int CNT_W          = 32
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  output logic [3:0] note,
  output logic       note_valid,
  output logic       busy,
  output logic [3:0] index,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SOUND,
    S_GAP
  } state_t;

  localparam logic [3:0] NOTE_NONE = 4'd8;
  localparam logic [3:0] LAST_IDX  = 4'd14;
  localparam logic [CNT_W-1:0] GAP_LOAD =
    CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  // Tune ROM: {note, beats}.
  function automatic logic [5:0] rom(input logic [3:0] i);
    logic [5:0] e;
    case (i)
      4'd0:    e = {4'd2, 2'd1};  // E
      4'd1:    e = {4'd2, 2'd1};  // E
      4'd2:    e = {4'd3, 2'd1};  // F
      4'd3:    e = {4'd4, 2'd1};  // G
      4'd4:    e = {4'd4, 2'd1};  // G
      4'd5:    e = {4'd3, 2'd1};  // F
      4'd6:    e = {4'd2, 2'd1};  // E
      4'd7:    e = {4'd1, 2'd1};  // D
      4'd8:    e = {4'd0, 2'd1};  // C4
      4'd9:    e = {4'd0, 2'd1};  // C4
      4'd10:   e = {4'd1, 2'd1};  // D
      4'd11:   e = {4'd2, 2'd1};  // E
      4'd12:   e = {4'd2, 2'd1};  // E
      4'd13:   e = {4'd1, 2'd1};  // D
      4'd14:   e = {4'd1, 2'd2};  // D, two beats
      default: e = {NOTE_NONE, 2'd1};
    endcase
    return e;
  endfunction

  // The counter runs down to 0. Sound lasts load+1 cycles and the gap lasts
  // GAP_TICKS cycles, so the whole entry is exactly beats*TICKS_PER_BEAT.
  function automatic logic [CNT_W-1:0] sound_load(input logic [3:0] i);
    logic [5:0] e;
    e = rom(i);
    return CNT_W'(e[1:0]) * CNT_W'(TICKS_PER_BEAT) - CNT_W'(GAP_TICKS) - CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic             done_d;

  // Target of "advance to the next entry"
  state_t           adv_state;
  logic [CNT_W-1:0] adv_cnt;
  logic [3:0]       adv_idx;
  logic             adv_done;

  logic [5:0]       next_entry;
  logic             sounding_d;

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    adv_state = S_SOUND;
    adv_cnt   = '0;
    adv_idx   = '0;
    adv_done  = 1'b0;
    if (idx_q < LAST_IDX) begin
      adv_idx = idx_q + 4'd1;
      adv_cnt = sound_load(idx_q + 4'd1);
    end else begin
      adv_done = 1'b1;
`ifdef SONG_SEQUENCER_LOOP_EN
      adv_state = S_SOUND;
      adv_cnt   = sound_load(4'd0);
`else
      adv_state = S_IDLE;
      adv_cnt   = '0;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SOUND;
          idx_d   = 4'd0;
          cnt_d   = sound_load(4'd0);
        end
      end
      S_SOUND: begin
        if (!pause) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (GAP_TICKS != 0) begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = adv_state;
            cnt_d   = adv_cnt;
            idx_d   = adv_idx;
            done_d  = adv_done;
          end
        end
      end
      S_GAP: begin
        if (!pause) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = adv_state;
            cnt_d   = adv_cnt;
            idx_d   = adv_idx;
            done_d  = adv_done;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = 4'd0;
      end
    endcase

    // stop overrides everything, including start and pause.
    if (stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = 4'd0;
      done_d  = 1'b0;
    end
  end

  // Outputs are registered from the next state. pause only mutes a running
  // entry; if it is high on the start edge, the first note still sounds.
  assign next_entry = rom(idx_d);
  assign sounding_d = (state_d == S_SOUND) && !(pause && (state_q != S_IDLE));

  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= 4'd0;
      done       <= 1'b0;
      note       <= NOTE_NONE;
      note_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      done       <= done_d;
      note       <= sounding_d ? next_entry[5:2] : NOTE_NONE;
      note_valid <= sounding_d;
      busy       <= (state_d != S_IDLE);
    end
  end

  assign index = idx_q;

endmodule
